morse_entry_ctrl: RTL

MORSE_ENTRY_CTRL -- requirements
Module: morse_entry_ctrl

---
 rtl/morse_entry_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/morse_entry_ctrl.sv
// Two-button Morse key entry: synchronizes and debounces dot/dash buttons,
// collects up to four symbols per letter and hands the letter off with valid/ready.
module morse_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 270000,
  parameter int unsigned GAP_CYC      = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button1,
  input  logic       button2,
  output logic [3:0] code_out,
  output logic [2:0] len_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       overflow,
  output logic [3:0] signal
);

  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Index 0 is the dot button, index 1 the dash button; levels are active-low.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    armed;
  logic [1:0]    press;
  logic [1:0]    warm;
  logic [DW-1:0] db_cnt [2];

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    code_nxt;
  logic [2:0]    len_nxt;
  logic [GW-1:0] gap;
  logic [GW-1:0] gap_nxt;
  logic          overflow_nxt;
  logic          valid_nxt;
  logic          accept_c;
  logic          sym_c;
  logic          both_released_c;

  // A button only becomes armed once seen released after reset, so a key held
  // through reset cannot generate a press until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      deb   <= 2'b11;
      armed <= 2'b00;
      press <= 2'b00;
      warm  <= 2'd0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {button2, button1};
      sync2 <= sync1;
      if (!warm[1]) warm <= warm + 2'd1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
            press[i]  <= armed[i] & ~sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
        if (warm[1] && sync2[i] && deb[i]) armed[i] <= 1'b1;
      end
    end
  end

  // Simultaneous presses, or a press while the other key is held, are ignored.
  assign accept_c        = (press[0] ^ press[1]) &&
                           !(press[0] && !deb[1]) &&
                           !(press[1] && !deb[0]);
  assign sym_c           = press[1];
  assign both_released_c = deb[0] & deb[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_out   <= 4'b0000;
      len_out    <= 3'd0;
      gap        <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      code_out   <= code_nxt;
      len_out    <= len_nxt;
      gap        <= gap_nxt;
      code_valid <= valid_nxt;
      overflow   <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    code_nxt     = code_out;
    len_nxt      = len_out;
    gap_nxt      = gap;
    overflow_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        gap_nxt = '0;
        if (accept_c) begin
          code_nxt  = {3'b000, sym_c};
          len_nxt   = 3'd1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (accept_c) begin
          code_nxt[len_out[1:0]] = sym_c;
          len_nxt = len_out + 3'd1;
          gap_nxt = '0;
          if (len_out == 3'd3) state_nxt = HOLD;
        end else if (both_released_c) begin
          if (gap == GW'(GAP_CYC - 1)) begin
            gap_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            gap_nxt = gap + GW'(1);
          end
        end else begin
          gap_nxt = '0;
        end
      end
      HOLD: begin
        overflow_nxt = accept_c;
        if (code_valid && code_ready) begin
          state_nxt = IDLE;
          code_nxt  = 4'b0000;
          len_nxt   = 3'd0;
          gap_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        code_nxt  = 4'b0000;
        len_nxt   = 3'd0;
        gap_nxt   = '0;
      end
    endcase
    valid_nxt = (state_nxt == HOLD);
  end

  assign signal = code_out;

endmodule
